unified_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between instruction fetch (IF) and the load/store unit (D).

---
 rtl/unified_mem_arbiter_if.sv | 36 +++
 rtl/unified_mem_arbiter.sv | 53 +++++
 tb/tb_unified_mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: request/grant/response bundle between IF, LSU, arbiter and unified RAM
//   slave  : arbiter side (takes requests and read data, drives grants, responses, RAM controls, stall)
//   master : environment side (fetch unit, LSU and RAM)
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;
  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );
  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported sync-read RAM between instruction fetch and the LSU
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : unified_mem_arbiter_if.slave (IF/LSU request-grant-response, RAM controls, stall)
//   ARB_STARVE_GUARD_EN (macro): after STARVE_LIMIT consecutive conflict losses IF wins the next conflict
module unified_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {NONE, RESP_IF, RESP_D} state_e;
  state_e state_q, state_d;
  logic   conflict, if_pri, if_gnt, d_gnt;
  assign conflict = bus.if_req_i & bus.d_req_i;
`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_max;
  assign cnt_max = cnt_q == CNT_W'(STARVE_LIMIT);
  assign if_pri  = conflict & cnt_max;
  assign cnt_d   = if_gnt ? '0 : (conflict && !cnt_max) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign if_pri = 1'b0;
`endif
  // Grants are forced low while reset is held so the RAM sees no access.
  assign d_gnt  = rst & bus.d_req_i & ~if_pri;
  assign if_gnt = rst & bus.if_req_i & ~d_gnt;
  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.stall_o     = bus.if_req_i & ~if_gnt;
  assign bus.mem_en_o    = if_gnt | d_gnt;
  assign bus.mem_we_o    = d_gnt & bus.d_we_i;
  assign bus.mem_addr_o  = d_gnt ? bus.d_addr_i : if_gnt ? bus.if_addr_i : '0;
  assign bus.mem_wdata_o = d_gnt ? bus.d_wdata_i : '0;
  // The owner of next cycle's read data; stores produce no response.
  assign state_d = if_gnt ? RESP_IF : (d_gnt && !bus.d_we_i) ? RESP_D : NONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= NONE;
    else      state_q <= state_d;
  end
  assign bus.if_rvalid_o = state_q == RESP_IF;
  assign bus.d_rvalid_o  = state_q == RESP_D;
  assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o   = bus.d_rvalid_o ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and random checks of unified_mem_arbiter against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LIM = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ref_mem [256];
  always @(posedge clk)
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o] = bus.mem_wdata_o;
      else bus.mem_rdata_i <= ram[bus.mem_addr_o];
    end
  int vecs = 0;
  int errs = 0;
  int m_pend = 0;
  int m_cnt = 0;
  logic [DW-1:0] m_pdata = '0;
  logic g_if, g_d, o_if;
  logic ip, dp, dwe;
  logic [AW-1:0] ia, da;
  logic [DW-1:0] dwd;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask
  // One cycle: drive requests, check every output against the model, advance the model, cross the edge.
  task automatic step(input logic ir, input logic [AW-1:0] iad, input logic dr, input logic we,
                      input logic [AW-1:0] dad, input logic [DW-1:0] wd);
    logic conf, ifwin;
    bus.if_req_i = ir; bus.if_addr_i = iad;
    bus.d_req_i = dr; bus.d_we_i = we; bus.d_addr_i = dad; bus.d_wdata_i = wd;
    #1;
    conf = ir & dr;
`ifdef ARB_STARVE_GUARD_EN
    ifwin = conf && m_cnt >= LIM;
`else
    ifwin = 1'b0;
`endif
    g_d  = dr & ~ifwin;
    g_if = ir & ~g_d;
    o_if = bus.if_gnt_o;
    chk("if_gnt", bus.if_gnt_o, g_if);
    chk("d_gnt", bus.d_gnt_o, g_d);
    chk("stall", bus.stall_o, ir & ~g_if);
    chk("mem_en", bus.mem_en_o, g_if | g_d);
    chk("mem_we", bus.mem_we_o, g_d & we);
    chk("mem_addr", bus.mem_addr_o, g_d ? dad : g_if ? iad : '0);
    chk("mem_wdata", bus.mem_wdata_o, g_d ? wd : '0);
    chk("if_rvalid", bus.if_rvalid_o, m_pend == 1);
    chk("d_rvalid", bus.d_rvalid_o, m_pend == 2);
    chk("if_rdata", bus.if_rdata_o, m_pend == 1 ? m_pdata : '0);
    chk("d_rdata", bus.d_rdata_o, m_pend == 2 ? m_pdata : '0);
    if (g_if) m_cnt = 0;
    else if (conf) m_cnt = m_cnt < LIM ? m_cnt + 1 : LIM;
    m_pend = g_if ? 1 : (g_d && !we) ? 2 : 0;
    if (g_if) m_pdata = ref_mem[iad];
    else if (g_d && !we) m_pdata = ref_mem[dad];
    if (g_d && we) ref_mem[dad] = wd;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.d_req_i = 0; bus.d_we_i = 0;
    bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.mem_rdata_i = '0;
    for (int i = 0; i < 256; i++) poke(AW'(i), $urandom);
    bus.if_req_i = 1; bus.d_req_i = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_if_gnt", bus.if_gnt_o, 0);
    chk("rst_d_gnt", bus.d_gnt_o, 0);
    chk("rst_mem_en", bus.mem_en_o, 0);
    chk("rst_if_rvalid", bus.if_rvalid_o, 0);
    chk("rst_d_rvalid", bus.d_rvalid_o, 0);
    bus.if_req_i = 0; bus.d_req_i = 0;
    @(posedge clk);
    #1;
    rst = 1;
    poke(8'h04, 32'h00500093);
    step(1, 8'h04, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'h08, 1, 0, 8'h40, $urandom);
    step(1, 8'h08, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);
    step(1, 8'h10, 0, 0, 0, 0);
    for (int a = 0; a < 3; a++) step(1, AW'(a), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      step(1, 8'h20, 1, 0, AW'(8'h30 + c), $urandom);
`ifdef ARB_STARVE_GUARD_EN
      chk("starve_if_gnt", o_if, c == 3);
`else
      chk("starve_if_gnt", o_if, 0);
`endif
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 8'h05, 0);
    rst = 0;
    #1;
    chk("midrst_d_rvalid", bus.d_rvalid_o, 0);
    chk("midrst_d_gnt", bus.d_gnt_o, 0);
    chk("midrst_mem_en", bus.mem_en_o, 0);
    m_pend = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    bus.d_req_i = 0;
    rst = 1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip && $urandom_range(3) != 0) begin ip = 1; ia = AW'($urandom_range(15)); end
      else if (ip && $urandom_range(15) == 0) ip = 0;
      if (!dp && $urandom_range(2) != 0) begin
        dp = 1; dwe = 1'($urandom_range(1)); da = AW'($urandom_range(15)); dwd = $urandom;
      end else if (dp && $urandom_range(15) == 0) dp = 0;
      step(ip, ia, dp, dwe, da, dwd);
      if (g_if) ip = 0;
      if (g_d) dp = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
